// File: rtl/defender_pkg.sv
// Shared constants and types for the defender game pipeline stages
// (invader, player-projectile and player hit-detect).
package defender_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ALIVE  = 2'd1,
      ST_INVULN = 2'd2,
      ST_DEAD   = 2'd3
   } hit_state_e;

   localparam int SCREEN_W          = 640;
   localparam int SCREEN_H          = 480;
   localparam int COORD_W           = 10;
   localparam int DEF_LIVES         = 3;
   localparam int DEF_HALF_W        = 10;
   localparam int DEF_HALF_H        = 10;
   localparam int DEF_INVULN_CYCLES = 1024;

   // Magnitude of a - b taken in 11-bit signed space, so 0 vs 1023 is 1023, not 1.
   function automatic logic [10:0] abs_diff11(input logic [9:0] a, input logic [9:0] b);
      logic signed [10:0] d;
      d = $signed({1'b0, a}) - $signed({1'b0, b});
      return d[10] ? 11'(-d) : 11'(d);
   endfunction

endpackage

// File: rtl/box_overlap.sv
// Combinational hitbox test: true when two points lie strictly inside a
// (2*HALF_W-1) x (2*HALF_H-1) window of each other.
module box_overlap
   import defender_pkg::*;
#(
   parameter int HALF_W = DEF_HALF_W,
   parameter int HALF_H = DEF_HALF_H
) (
   input  logic [9:0] a_x_i,
   input  logic [9:0] a_y_i,
   input  logic [9:0] b_x_i,
   input  logic [9:0] b_y_i,
   output logic       overlap_o
);

   localparam logic [10:0] HALF_W_L = 11'(HALF_W);
   localparam logic [10:0] HALF_H_L = 11'(HALF_H);

   logic [10:0] dx_mag;
   logic [10:0] dy_mag;

   assign dx_mag    = abs_diff11(a_x_i, b_x_i);
   assign dy_mag    = abs_diff11(a_y_i, b_y_i);
   assign overlap_o = (dx_mag < HALF_W_L) && (dy_mag < HALF_H_L);

endmodule

// File: rtl/player_hit_detect.sv
// Player hit detection: registered projectile/player overlap followed by a
// lives / invulnerability / game-over FSM that retires enemy shots.
module player_hit_detect
   import defender_pkg::*;
#(
   parameter int HALF_W        = DEF_HALF_W,
   parameter int HALF_H        = DEF_HALF_H,
   parameter int LIVES         = DEF_LIVES,
   parameter int INVULN_CYCLES = DEF_INVULN_CYCLES
) (
   input  logic       clk_4,
   input  logic       clr,
   input  logic       play,
   input  logic [9:0] enemy_projectiles_x,
   input  logic [9:0] enemy_projectiles_y,
   input  logic [9:0] player_x,
   input  logic [9:0] player_y,
   output logic       destroy,
   output logic       hit,
   output logic [1:0] lives,
   output logic       invuln,
   output logic       game_over
);

   localparam int              CNT_W    = $clog2(INVULN_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(INVULN_CYCLES - 1);
   localparam logic [1:0]      LIVES_L  = 2'(LIVES);

   logic             box_hit;
   logic             overlap_d;
   logic             overlap_q;
   logic             blank;
   logic             blank_q;
   logic             destroy_q;
   logic             hit_q;
   logic             invuln_q;
   logic             game_over_q;
   logic [1:0]       lives_q;
   logic [CNT_W-1:0] cnt_q;
   hit_state_e       state_q;

   box_overlap #(
      .HALF_W (HALF_W),
      .HALF_H (HALF_H)
   ) u_box (
      .a_x_i     (enemy_projectiles_x),
      .a_y_i     (enemy_projectiles_y),
      .b_x_i     (player_x),
      .b_y_i     (player_y),
      .overlap_o (box_hit)
   );

   assign overlap_d = (enemy_projectiles_y != 10'd0) && box_hit;

   // The overlap register still reflects a retired projectile for the pulse
   // cycle and the one after it, so both are masked.
   assign blank = destroy_q | blank_q;

   always_ff @(posedge clk_4) begin
      if (!clr) begin
         state_q     <= ST_IDLE;
         overlap_q   <= 1'b0;
         blank_q     <= 1'b0;
         destroy_q   <= 1'b0;
         hit_q       <= 1'b0;
         invuln_q    <= 1'b0;
         game_over_q <= 1'b0;
         lives_q     <= LIVES_L;
         cnt_q       <= '0;
      end else begin
         overlap_q <= overlap_d;
         blank_q   <= destroy_q;
         destroy_q <= 1'b0;
         hit_q     <= 1'b0;
         if (!play) begin
            state_q     <= ST_IDLE;
            lives_q     <= LIVES_L;
            cnt_q       <= '0;
            invuln_q    <= 1'b0;
            game_over_q <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  lives_q <= LIVES_L;
                  state_q <= ST_ALIVE;
               end
               ST_ALIVE: begin
                  if (overlap_q && !blank) begin
                     destroy_q <= 1'b1;
                     hit_q     <= 1'b1;
                     if (lives_q <= 2'd1) begin
                        lives_q     <= 2'd0;
                        game_over_q <= 1'b1;
                        state_q     <= ST_DEAD;
                     end else begin
                        lives_q  <= lives_q - 2'd1;
                        cnt_q    <= CNT_LOAD;
                        invuln_q <= 1'b1;
                        state_q  <= ST_INVULN;
                     end
                  end
               end
               ST_INVULN: begin
                  if (overlap_q && !blank) begin
                     destroy_q <= 1'b1;
                  end
                  if (cnt_q == '0) begin
                     invuln_q <= 1'b0;
                     state_q  <= ST_ALIVE;
                  end else begin
                     cnt_q <= cnt_q - 1'b1;
                  end
               end
               ST_DEAD: begin
                  game_over_q <= 1'b1;
               end
               default: begin
                  state_q <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign destroy   = destroy_q;
   assign hit       = hit_q;
   assign lives     = lives_q;
   assign invuln    = invuln_q;
   assign game_over = game_over_q;

endmodule

// File: tb/tb_player_hit_detect.sv
// Self-checking bench for player_hit_detect: directed scenarios plus random
// play, every cycle compared against a game-rule reference model.
module tb_player_hit_detect;

   localparam int HW = 10;
   localparam int HH = 10;
   localparam int NL = 3;
   localparam int IC = 1024;

   logic       clk_4 = 1'b0;
   logic       clr;
   logic       play;
   logic [9:0] px, py, plx, ply;
   logic       destroy, hit, invuln, game_over;
   logic [1:0] lives;

   player_hit_detect #(
      .HALF_W (HW), .HALF_H (HH), .LIVES (NL), .INVULN_CYCLES (IC)
   ) dut (
      .clk_4               (clk_4),
      .clr                 (clr),
      .play                (play),
      .enemy_projectiles_x (px),
      .enemy_projectiles_y (py),
      .player_x            (plx),
      .player_y            (ply),
      .destroy             (destroy),
      .hit                 (hit),
      .lives               (lives),
      .invuln              (invuln),
      .game_over           (game_over)
   );

   always #5 clk_4 = ~clk_4;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: game-level bookkeeping by edge number.
   int m_edge         = 0;
   bit m_ov_pipe      = 0;
   bit m_playing      = 0;
   bit m_dead         = 0;
   int m_lives        = NL;
   int m_inv_left     = 0;
   int m_last_destroy = -100;
   logic [5:0] exp_v;
   logic [5:0] got_v;
   int n_d, n_h, n_inv;

   assign got_v = {destroy, hit, lives, invuln, game_over};

   function automatic bit geo_overlap();
      int dx, dy;
      dx = int'(px) - int'(plx);
      dy = int'(py) - int'(ply);
      if (dx < 0) dx = -dx;
      if (dy < 0) dy = -dy;
      return (py != 0) && (dx < HW) && (dy < HH);
   endfunction

   // Advance one edge, update the model from pre-edge inputs, settle outputs.
   task automatic tick();
      bit seen, valid, d, h;
      @(posedge clk_4);
      m_edge++;
      seen      = m_ov_pipe;
      m_ov_pipe = geo_overlap();
      valid     = seen && (m_edge - m_last_destroy > 2);
      d = 0;
      h = 0;
      if (!clr) begin
         m_ov_pipe = 0; m_playing = 0; m_dead = 0; m_lives = NL;
         m_inv_left = 0; m_last_destroy = -100;
      end else if (!play) begin
         m_playing = 0; m_dead = 0; m_lives = NL; m_inv_left = 0;
      end else if (!m_playing) begin
         m_playing = 1; m_lives = NL;
      end else if (m_dead) begin
         d = 0;
      end else if (m_inv_left > 0) begin
         d = valid;
         m_inv_left--;
      end else if (valid) begin
         d = 1; h = 1;
         m_lives--;
         if (m_lives == 0) m_dead = 1;
         else m_inv_left = IC;
      end
      if (d) m_last_destroy = m_edge;
      exp_v = {d, h, 2'(m_lives), (m_inv_left > 0), m_dead};
      #1;
      n_d   += int'(destroy);
      n_h   += int'(hit);
      n_inv += int'(invuln);
   endtask

   task automatic set_proj(input int x, input int y);
      px = 10'(x);
      py = 10'(y);
   endtask

   task automatic test_reset();
      clr = 1'b0; play = 1'b1;
      plx = 10'd220; ply = 10'd440; set_proj(220, 440);
      repeat (3) begin
         tick();
         vectors++;
         if (got_v !== 6'b00_11_0_0) begin
            miscompares++;
            $display("FAIL reset_const edge=%0d got=%b want=%b", m_edge, got_v, 6'b00_11_0_0);
         end
         vectors++;
         if (got_v !== exp_v) begin
            miscompares++;
            $display("FAIL reset_model edge=%0d got=%b want=%b", m_edge, got_v, exp_v);
         end
      end
      set_proj(0, 0);
      clr = 1'b1;
      repeat (4) begin
         tick();
         vectors++;
         if (got_v !== exp_v) begin
            miscompares++;
            $display("FAIL reset_release edge=%0d got=%b want=%b", m_edge, got_v, exp_v);
         end
      end
      $display("[tb] reset done lives=%0d", lives);
   endtask

   task automatic test_direct_hit();
      n_d = 0; n_h = 0; n_inv = 0;
      plx = 10'd220; ply = 10'd440; set_proj(225, 435);
      $display("[tb] shot direct proj=(225,435) player=(220,440)");
      repeat (3) begin
         tick();
         vectors++;
         if (got_v !== exp_v) begin
            miscompares++;
            $display("FAIL direct_hit edge=%0d got=%b want=%b", m_edge, got_v, exp_v);
         end
      end
      set_proj(0, 0);
      repeat (1100) begin
         tick();
         vectors++;
         if (got_v !== exp_v) begin
            miscompares++;
            $display("FAIL direct_wait edge=%0d got=%b want=%b", m_edge, got_v, exp_v);
         end
      end
      vectors++;
      if (n_d !== 1 || n_h !== 1) begin
         miscompares++;
         $display("FAIL direct_pulses destroys=%0d hits=%0d want 1/1", n_d, n_h);
      end
      vectors++;
      if (n_inv !== IC) begin
         miscompares++;
         $display("FAIL direct_invuln_len got=%0d want=%0d", n_inv, IC);
      end
      vectors++;
      if (lives !== 2'd2 || invuln !== 1'b0) begin
         miscompares++;
         $display("FAIL direct_after lives=%0d invuln=%b want 2/0", lives, invuln);
      end
   endtask

   task automatic test_boundary();
      int tbl [4][5] = '{'{300, 200, 310, 200, 0},   // |dx| = 10
                         '{5,   200, 1020, 200, 0},  // no wrap at 0/1023
                         '{100, 5,   100, 0,   0},   // y = 0 is empty slot
                         '{300, 200, 291, 205, 1}};  // |dx| = 9
      for (int c = 0; c < 4; c++) begin
         n_h = 0;
         plx = 10'(tbl[c][0]); ply = 10'(tbl[c][1]);
         set_proj(tbl[c][2], tbl[c][3]);
         $display("[tb] shot boundary%0d proj=(%0d,%0d) player=(%0d,%0d)",
                  c, tbl[c][2], tbl[c][3], tbl[c][0], tbl[c][1]);
         repeat (3) begin
            tick();
            vectors++;
            if (got_v !== exp_v) begin
               miscompares++;
               $display("FAIL boundary%0d edge=%0d got=%b want=%b", c, m_edge, got_v, exp_v);
            end
         end
         set_proj(0, 0);
         repeat (3) begin
            tick();
            vectors++;
            if (got_v !== exp_v) begin
               miscompares++;
               $display("FAIL boundary%0d_clr edge=%0d got=%b want=%b", c, m_edge, got_v, exp_v);
            end
         end
         vectors++;
         if (n_h !== tbl[c][4]) begin
            miscompares++;
            $display("FAIL boundary%0d_hits got=%0d want=%0d", c, n_h, tbl[c][4]);
         end
      end
   endtask

   task automatic test_invuln_overlap();
      n_d = 0; n_h = 0;
      plx = 10'd400; ply = 10'd400; set_proj(405, 397);
      $display("[tb] shot invuln proj=(405,397) player=(400,400)");
      repeat (3) begin
         tick();
         vectors++;
         if (got_v !== exp_v) begin
            miscompares++;
            $display("FAIL invuln_ovl edge=%0d got=%b want=%b", m_edge, got_v, exp_v);
         end
      end
      set_proj(0, 0);
      repeat (3) begin
         tick();
         vectors++;
         if (got_v !== exp_v) begin
            miscompares++;
            $display("FAIL invuln_ovl_clr edge=%0d got=%b want=%b", m_edge, got_v, exp_v);
         end
      end
      vectors++;
      if (n_d !== 1 || n_h !== 0 || lives !== 2'd1 || invuln !== 1'b1) begin
         miscompares++;
         $display("FAIL invuln_once destroys=%0d hits=%0d lives=%0d inv=%b want 1/0/1/1",
                  n_d, n_h, lives, invuln);
      end
      repeat (1100) begin
         tick();
         vectors++;
         if (got_v !== exp_v) begin
            miscompares++;
            $display("FAIL invuln_wait edge=%0d got=%b want=%b", m_edge, got_v, exp_v);
         end
      end
   endtask

   task automatic test_game_over();
      play = 1'b0;
      repeat (2) tick();
      vectors++;
      if (lives !== 2'd3 || game_over !== 1'b0) begin
         miscompares++;
         $display("FAIL go_reload lives=%0d go=%b want 3/0", lives, game_over);
      end
      play = 1'b1;
      repeat (2) tick();
      plx = 10'd100; ply = 10'd300;
      for (int k = 0; k < 3; k++) begin
         set_proj(100 + k, 300 - k);
         $display("[tb] shot gameover%0d proj=(%0d,%0d) player=(100,300)", k, 100 + k, 300 - k);
         repeat (3) begin
            tick();
            vectors++;
            if (got_v !== exp_v) begin
               miscompares++;
               $display("FAIL go_hit%0d edge=%0d got=%b want=%b", k, m_edge, got_v, exp_v);
            end
         end
         set_proj(0, 0);
         repeat ((k < 2) ? 1050 : 3) begin
            tick();
            vectors++;
            if (got_v !== exp_v) begin
               miscompares++;
               $display("FAIL go_wait%0d edge=%0d got=%b want=%b", k, m_edge, got_v, exp_v);
            end
         end
      end
      vectors++;
      if (lives !== 2'd0 || game_over !== 1'b1) begin
         miscompares++;
         $display("FAIL go_dead lives=%0d go=%b want 0/1", lives, game_over);
      end
      n_d = 0;
      set_proj(102, 301);
      repeat (6) begin
         tick();
         vectors++;
         if (got_v !== exp_v) begin
            miscompares++;
            $display("FAIL go_deadovl edge=%0d got=%b want=%b", m_edge, got_v, exp_v);
         end
      end
      vectors++;
      if (n_d !== 0) begin
         miscompares++;
         $display("FAIL go_nodestroy got=%0d want=0", n_d);
      end
      set_proj(0, 0);
      play = 1'b0;
      tick();
      vectors++;
      if (lives !== 2'd3 || game_over !== 1'b0) begin
         miscompares++;
         $display("FAIL go_exit lives=%0d go=%b want 3/0", lives, game_over);
      end
   endtask

   task automatic test_play_fall();
      play = 1'b1;
      repeat (2) tick();
      plx = 10'd50; ply = 10'd60; set_proj(52, 58);
      repeat (3) tick();
      set_proj(0, 0);
      repeat (100) tick();
      set_proj(48, 63);
      $display("[tb] shot playfall proj=(48,63) player=(50,60)");
      tick();
      play = 1'b0;
      tick();
      vectors++;
      if (destroy !== 1'b0 || hit !== 1'b0 || invuln !== 1'b0 || lives !== 2'd3) begin
         miscompares++;
         $display("FAIL playfall d=%b h=%b inv=%b lives=%0d want 0/0/0/3",
                  destroy, hit, invuln, lives);
      end
      vectors++;
      if (got_v !== exp_v) begin
         miscompares++;
         $display("FAIL playfall_model edge=%0d got=%b want=%b", m_edge, got_v, exp_v);
      end
      set_proj(0, 0);
   endtask

   task automatic test_random();
      play = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 499) == 0) clr = 1'b0;
         else clr = 1'b1;
         if ($urandom_range(0, 199) == 0) play = ~play;
         if ($urandom_range(0, 15) == 0) begin
            plx = 10'($urandom_range(0, 1023));
            ply = 10'($urandom_range(0, 1023));
         end
         if ($urandom_range(0, 3) == 0) begin
            set_proj(0, 0);
         end else begin
            px = plx + 10'($urandom_range(0, 30)) - 10'd15;
            py = ply + 10'($urandom_range(0, 30)) - 10'd15;
         end
         tick();
         vectors++;
         if (got_v !== exp_v) begin
            miscompares++;
            $display("FAIL random edge=%0d got=%b want=%b", m_edge, got_v, exp_v);
         end
      end
      $display("[tb] random phase done at edge %0d", m_edge);
   endtask

   initial begin
      clr = 1'b0; play = 1'b0;
      px = '0; py = '0; plx = '0; ply = '0;
      test_reset();
      test_direct_hit();
      test_boundary();
      test_invuln_overlap();
      test_game_over();
      test_play_fall();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
